// File: rtl/axi_w_dest_router_pkg.sv
// Shared types for the W-channel destination router.
// No logic; no latency; no backpressure.
package axi_w_dest_router_pkg;

    typedef enum logic {
        ST_ROUTE = 1'b0,
        ST_SINK  = 1'b1
    } route_state_e;

endpackage

// File: rtl/axi_dest_fifo.sv
// One-hot destination FIFO, written in AW order and read from the head.
// Latency: 1 cycle push-to-head, no bypass. Backpressure: full blocks push; push while full is dropped.
module axi_dest_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign data_o = r_mem[r_rptr];

    // Pointers wrap naturally; the extra count bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full))
                else $warning("axi_dest_fifo: push while full dropped");
        end
    end

endmodule

// File: rtl/axi_w_dest_router.sv
// Steers W bursts to the one-hot destination at the FIFO head, or sinks an errored burst.
// Latency: zero-cycle combinational W path. Backpressure: wready_o follows the selected port's wready_i.
module axi_w_dest_router
    import axi_w_dest_router_pkg::*;
#(
    parameter int N_INIT_PORT = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_DEST_i,
    input  logic [N_INIT_PORT-1:0] DEST_i,
    output logic                   grant_FIFO_DEST_o,
    input  logic                   wvalid_i,
    input  logic                   wlast_i,
    output logic                   wready_o,
    output logic [N_INIT_PORT-1:0] wvalid_o,
    input  logic [N_INIT_PORT-1:0] wready_i,
    input  logic                   handle_error_i,
    output logic                   wdata_error_completed_o
);

    route_state_e           r_state;
    route_state_e           w_state_nxt;
    logic [N_INIT_PORT-1:0] w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_head_rdy;
    logic                   w_route_fire;
    logic                   w_pop;

    assign w_head_rdy   = |(wready_i & w_head);
    assign w_route_fire = ~w_empty & wvalid_i & w_head_rdy;
    // Destinations pushed during a sink must stay put until routing resumes.
    assign w_pop        = (r_state == ST_ROUTE) & w_route_fire & wlast_i;

    assign grant_FIFO_DEST_o = ~w_full;

    axi_dest_fifo #(
        .DATA_WIDTH (N_INIT_PORT),
        .DEPTH      (FIFO_DEPTH)
    ) u_dest_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_DEST_i),
        .pop    (w_pop),
        .data_i (DEST_i),
        .data_o (w_head),
        .full   (w_full),
        .empty  (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ROUTE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt             = r_state;
        wvalid_o                = '0;
        wready_o                = 1'b0;
        wdata_error_completed_o = 1'b0;
        case (r_state)
            ST_ROUTE: begin
                if (!w_empty) begin
                    wvalid_o = {N_INIT_PORT{wvalid_i}} & w_head;
                    wready_o = w_head_rdy;
                end else if (handle_error_i) begin
                    w_state_nxt = ST_SINK;
                end
            end
            ST_SINK: begin
                wready_o = 1'b1;
                if (wvalid_i && wlast_i) begin
                    wdata_error_completed_o = 1'b1;
                    w_state_nxt             = ST_ROUTE;
                end
            end
            default: w_state_nxt = ST_ROUTE;
        endcase
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (!w_empty) begin
                assert ($onehot(w_head))
                    else $error("axi_w_dest_router: head destination not one-hot");
            end
            assert (!(r_state == ST_ROUTE && handle_error_i && !w_empty))
                else $warning("axi_w_dest_router: handle_error held off until earlier bursts drain");
        end
    end

endmodule

// File: tb/tb_axi_w_dest_router.sv
module tb_axi_w_dest_router;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         push_DEST_i;
    logic [N-1:0] DEST_i;
    logic         grant_FIFO_DEST_o;
    logic         wvalid_i;
    logic         wlast_i;
    logic         wready_o;
    logic [N-1:0] wvalid_o;
    logic [N-1:0] wready_i;
    logic         handle_error_i;
    logic         wdata_error_completed_o;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending destinations plus a sink flag.
    logic [N-1:0] q[$];
    bit           m_sink;
    bit           m_acc;

    axi_w_dest_router #(
        .N_INIT_PORT (N),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .push_DEST_i             (push_DEST_i),
        .DEST_i                  (DEST_i),
        .grant_FIFO_DEST_o       (grant_FIFO_DEST_o),
        .wvalid_i                (wvalid_i),
        .wlast_i                 (wlast_i),
        .wready_o                (wready_o),
        .wvalid_o                (wvalid_o),
        .wready_i                (wready_i),
        .handle_error_i          (handle_error_i),
        .wdata_error_completed_o (wdata_error_completed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_wvalid;
        logic         e_wready;
        logic         e_done;
        e_wvalid = '0;
        e_wready = 1'b0;
        e_done   = 1'b0;
        if (rst_n && m_sink) begin
            e_wready = 1'b1;
            e_done   = wvalid_i && wlast_i;
        end else if (q.size() > 0) begin
            e_wready = (wready_i & q[0]) != '0;
            e_wvalid = wvalid_i ? q[0] : '0;
        end
        m_acc = wvalid_i && e_wready;
        chk("wvalid_o", wvalid_o, e_wvalid);
        chk("wready_o", wready_o, e_wready);
        chk("grant", grant_FIFO_DEST_o, q.size() < DEPTH);
        chk("err_done", wdata_error_completed_o, e_done);
    endtask

    task automatic model_update();
        bit popped;
        bit pushed;
        popped = !m_sink && q.size() > 0 && wvalid_i && wlast_i && m_acc;
        pushed = push_DEST_i && q.size() < DEPTH;
        if (m_sink) begin
            if (wvalid_i && wlast_i) m_sink = 0;
        end else if (q.size() == 0 && handle_error_i) begin
            m_sink = 1;
        end
        if (popped) void'(q.pop_front());
        if (pushed) q.push_back(DEST_i);
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
        push_DEST_i    = 1'b0;
        handle_error_i = 1'b0;
    endtask

    task automatic run_burst(input int len);
        int beats = 0;
        int guard = 0;
        wvalid_i = 1'b1;
        while (beats < len && guard < 200) begin
            wlast_i = (beats == len - 1);
            cycle();
            if (m_acc) beats++;
            guard++;
        end
        wvalid_i = 1'b0;
        wlast_i  = 1'b0;
        chk("burst_beats", beats, len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n          = 1'b0;
        push_DEST_i    = 1'b0;
        DEST_i         = '0;
        wvalid_i       = 1'b0;
        wlast_i        = 1'b0;
        wready_i       = '1;
        handle_error_i = 1'b0;
        m_sink         = 0;
        #1;
        chk("rst_grant", grant_FIFO_DEST_o, 1'b1);
        chk("rst_wready", wready_o, 1'b0);
        chk("rst_wvalid", wvalid_o, 8'h00);
        chk("rst_done", wdata_error_completed_o, 1'b0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // Push and burst start together: routing only from the next cycle.
        push_DEST_i = 1'b1;
        DEST_i      = 8'h04;
        run_burst(4);
        cycle();
        chk("empty_after_burst", grant_FIFO_DEST_o, 1'b1);

        // Fill to capacity.
        for (int i = 0; i < 4; i++) begin
            push_DEST_i = 1'b1;
            DEST_i      = 8'h01 << i;
            cycle();
        end
        chk("full_grant", grant_FIFO_DEST_o, 1'b0);

        // Push while full coinciding with a last-beat pop is dropped.
        wvalid_i = 1'b1;
        wlast_i  = 1'b0;
        cycle();
        wlast_i     = 1'b1;
        push_DEST_i = 1'b1;
        DEST_i      = 8'h80;
        cycle();
        wvalid_i = 1'b0;
        wlast_i  = 1'b0;
        chk("count_3_grant", grant_FIFO_DEST_o, 1'b1);
        run_burst(1);

        // Port 2 stalls for three cycles mid-burst.
        wready_i = 8'hFB;
        wvalid_i = 1'b1;
        wlast_i  = 1'b0;
        repeat (3) cycle();
        chk("stall_wvalid", wvalid_o, 8'h04);
        wready_i = '1;
        run_burst(2);
        run_burst(3);

        // Error sink with a push arriving during the sink.
        handle_error_i = 1'b1;
        cycle();
        push_DEST_i = 1'b1;
        DEST_i      = 8'h10;
        run_burst(3);
        run_burst(1);

        // Single-beat errored burst.
        handle_error_i = 1'b1;
        cycle();
        run_burst(1);

        // Reset mid-burst with two entries stored.
        push_DEST_i = 1'b1;
        DEST_i      = 8'h20;
        cycle();
        push_DEST_i = 1'b1;
        DEST_i      = 8'h40;
        cycle();
        wvalid_i = 1'b1;
        wlast_i  = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_wvalid", wvalid_o, 8'h00);
        chk("midrst_wready", wready_o, 1'b0);
        chk("midrst_grant", grant_FIFO_DEST_o, 1'b1);
        q.delete();
        m_sink   = 0;
        wvalid_i = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_grant", grant_FIFO_DEST_o, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            push_DEST_i    = (q.size() < DEPTH) && ($urandom_range(2, 0) == 0);
            DEST_i         = 8'h01 << $urandom_range(7, 0);
            wvalid_i       = ($urandom_range(3, 0) != 0);
            wlast_i        = ($urandom_range(2, 0) == 0);
            wready_i       = N'($urandom);
            handle_error_i = !m_sink && (q.size() == 0) && ($urandom_range(7, 0) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
